sram_ram_bridge: RTL and testbench
==================================

# sram_ram_bridge

Single-outstanding bridge that converts the CPU's SRAM-like request/response bus (req/addr_ok/data_ok) into the single-port asynchronous-read RAM port (a/d/we/spo) used by the SoC testbench's instruction and data RAMs. The RAM has only a full-word write enable, so the bridge performs read-modify-write for partial byte strobes. One instance sits between each CPU memory port and its RAM model.

## Interface
- ADDR_WIDTH, 15, RAM word-address width; byte address bits [ADDR_WIDTH+1:2] select the word.
- Data width is fixed at 32 bits, with 4 byte strobes.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  CPU request valid; held until accepted.
- wr  in  1  1 = write, 0 = read.
- wstrb  in  4  byte write strobes; ignored for reads.
- addr  in  32  byte address; bits [1:0] and bits above ADDR_WIDTH+1 are ignored (aliasing).
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  one-cycle completion pulse for the accepted request.
- rdata  out  32  read data, valid while data_ok is high.
- ram_a  out  ADDR_WIDTH  RAM word address.
- ram_d  out  32  RAM write data.
- ram_we  out  1  RAM full-word write enable.
- ram_spo  in  32  RAM asynchronous read data; high-Z while ram_we is high.

## Operation
- States: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- addr_ok = (state == IDLE) && !reset; this is combinational.
- Handshake occurs when req && addr_ok at a rising edge. On handshake the bridge latches wr, wstrb, wdata and addr[ADDR_WIDTH+1:2] into ram_a.
- Transitions from IDLE on handshake:
  - read → READ
  - write with wstrb == 4'hF → WRITE
  - write with wstrb == 4'h0 → RESP (no RAM access)
  - any other write → READ
- READ: ram_we = 0. At the end of the cycle, ram_spo is captured into the old-word register. Next state is WRITE for a write, RESP for a read.
- WRITE: ram_we = 1 for exactly this cycle. ram_d is the merged word: byte i = wstrb[i] ? wdata byte i : old byte i (old word is unused when wstrb == 4'hF). Next state is RESP.
- RESP: data_ok = 1 for exactly one cycle.
  - rdata is the captured word for reads.
  - rdata is the written (merged) word for writes.
  - rdata is the unchanged old value for wstrb == 0.
  - Next state is IDLE.
- req in any state other than IDLE is ignored. The master must hold req, wr, wstrb, addr and wdata stable until addr_ok.
- ram_spo is sampled only in READ, never while ram_we is high.
- Reset mid-operation: at the reset edge the state returns to IDLE and the in-flight request is dropped. ram_we is low from that edge, no data_ok is issued, and RAM contents are untouched unless the WRITE cycle had already completed.

## Timing
- Reset values:
  - addr_ok 0 while reset is high, 1 from the first cycle after reset.
  - data_ok 0, rdata 0, ram_a 0, ram_d 0, ram_we 0.
- Latency, with the handshake at edge k:
  - Read: READ in cycle k..k+1, data_ok in cycle k+1..k+2.
  - Full write: ram_we in cycle k..k+1 (RAM updated at edge k+1), data_ok in cycle k+1..k+2.
  - Partial write: READ, then WRITE, with data_ok in cycle k+2..k+3.
  - wstrb == 0 write: data_ok in cycle k..k+1.
- Back-to-back: the next handshake is possible at the first edge after the RESP cycle. Read throughput is one per 3 cycles.
- ram_we is never high for more than one consecutive cycle per request.
- data_ok and addr_ok are never high in the same cycle.

## Test plan
- Full write of addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF → ram_we high one cycle with ram_a = 4 and ram_d = 0xDEADBEEF; data_ok one cycle after the handshake edge.
- Read of addr 0x10 → ram_we stays 0, data_ok one cycle after the handshake, rdata = 0xDEADBEEF. Then read addr 0x20010 (aliases to word 4) → rdata = 0xDEADBEEF.
- Partial write of addr 0x10, wdata 0x11223344, wstrb 4'b0101 → READ cycle, then ram_we with ram_d = 0xDE22BE44; data_ok two cycles after the handshake; a subsequent read returns 0xDE22BE44.
- Write with wstrb 4'h0 to addr 0x10 → ram_we never asserted, data_ok in the cycle right after the handshake, RAM word still 0xDE22BE44.
- req held high for two reads (addr 0x0, then top word 0x1FFFC) → ram_a = 0, then 0x7FFF. The second addr_ok appears only in the cycle after the first data_ok, and each data_ok carries the correct word.
- reset asserted for one edge while in READ of a partial write → state IDLE, ram_we never asserted, no data_ok, RAM unchanged; addr_ok returns the cycle after reset drops.

Source files
------------

// File: rtl/sram_ram_bridge.sv
// rtl/sram_ram_bridge.sv - SRAM-like req/addr_ok/data_ok bus to async-read single-port RAM bridge
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req, wr, wstrb, addr,      CPU request side (held until addr_ok)
//   wdata
//   addr_ok                    request accepted this cycle (combinational)
//   data_ok, rdata             one-cycle completion pulse and its data
//   ram_a, ram_d, ram_we       RAM word address, write data, full-word write enable
//   ram_spo                    RAM asynchronous read data
module sram_ram_bridge #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wr,
    input  logic [3:0]            wstrb,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [31:0]           ram_d,
    output logic                  ram_we,
    input  logic [31:0]           ram_spo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] old_word;
    logic [31:0] merged;

    // Byte offset and the aliased high address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign addr_ok = (state == IDLE) && !reset;

    // Merge is built from the live RAM output so the WRITE cycle can follow
    // READ directly without an extra cycle through old_word.
    always_comb begin
        merged = ram_spo;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            old_word <= 32'h0;
            data_ok  <= 1'b0;
            rdata    <= 32'h0;
            ram_a    <= '0;
            ram_d    <= 32'h0;
            ram_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_ok <= 1'b0;
                    ram_we  <= 1'b0;
                    // addr_ok is high here, so req alone is the handshake.
                    if (req) begin
                        wr_q    <= wr;
                        wstrb_q <= wstrb;
                        wdata_q <= wdata;
                        ram_a   <= addr[ADDR_WIDTH+1:2];
                        if (!wr) begin
                            state <= READ;
                        end else if (wstrb == 4'hF) begin
                            ram_we <= 1'b1;
                            ram_d  <= wdata;
                            state  <= WRITE;
                        end else if (wstrb == 4'h0) begin
                            data_ok <= 1'b1;
                            rdata   <= old_word;
                            state   <= RESP;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    old_word <= ram_spo;
                    if (wr_q) begin
                        ram_d  <= merged;
                        ram_we <= 1'b1;
                        state  <= WRITE;
                    end else begin
                        rdata   <= ram_spo;
                        data_ok <= 1'b1;
                        state   <= RESP;
                    end
                end
                WRITE: begin
                    ram_we  <= 1'b0;
                    rdata   <= ram_d;
                    data_ok <= 1'b1;
                    state   <= RESP;
                end
                default: begin
                    data_ok <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ram_bridge.sv
// tb/tb_sram_ram_bridge.sv - scoreboard testbench for sram_ram_bridge
module tb_sram_ram_bridge;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          wr;
    logic [3:0]    wstrb;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [31:0]   rdata;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_d;
    logic          ram_we;
    logic [31:0]   ram_spo;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int we_run   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        int            due;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    sram_ram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata),
        .ram_a   (ram_a),
        .ram_d   (ram_d),
        .ram_we  (ram_we),
        .ram_spo (ram_spo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_a] <= ram_d;
    end

    assign ram_spo = mem[ram_a];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every data_ok and every ram_we cycle against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_ok) begin
                check("data_ok_with_addr_ok", {31'b0, addr_ok}, 32'd0);
                if (rsp_q.size() == 0) begin
                    check("unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rdata", rdata, r.data);
                    check("data_ok_cycle", cyc, r.due);
                end
            end
            if (ram_we) begin
                we_run++;
                check("ram_we_single_cycle", we_run, 1);
                if (wr_q.size() == 0) begin
                    check("unexpected_ram_we", 32'd1, 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("ram_a", {17'b0, ram_a}, {17'b0, w.a});
                    check("ram_d", ram_d, w.d);
                    check("ram_we_cycle", cyc, w.due);
                end
            end else begin
                we_run = 0;
            end
        end
    end

    // Issue one request from a negedge; returns the handshake edge number and
    // leaves the bench at a negedge. exp_we: expect a RAM write with we_lat.
    task automatic do_req(input logic w, input logic [3:0] s, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                          input logic exp_we, input logic [AW-1:0] exp_a,
                          input logic [31:0] exp_d, input int we_lat, input logic hold,
                          output int hs);
        int i;
        req = 1'b1; wr = w; wstrb = s; addr = ad; wdata = wd;
        #1;
        for (i = 0; i < 20 && !addr_ok; i++) begin
            @(negedge clk);
            #1;
        end
        if (!addr_ok) check("addr_ok_timeout", 32'd0, 32'd1);
        hs = cyc + 1;
        rsp_q.push_back('{data: exp_rd, due: hs + lat});
        if (exp_we) wr_q.push_back('{a: exp_a, d: exp_d, due: hs + we_lat});
        @(posedge clk);
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int hs1, hs2;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[0]       = 32'hA5A5_0001;
        mem[15'h7FFF] = 32'h7FFF_C0DE;
        reset = 1'b1; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_addr_ok", {31'b0, addr_ok}, 32'd0);
        check("reset_data_ok", {31'b0, data_ok}, 32'd0);
        check("reset_rdata",   rdata, 32'd0);
        check("reset_ram_a",   {17'b0, ram_a}, 32'd0);
        check("reset_ram_d",   ram_d, 32'd0);
        check("reset_ram_we",  {31'b0, ram_we}, 32'd0);
        reset = 1'b0;
        #1;
        check("addr_ok_after_reset", {31'b0, addr_ok}, 32'd1);
        @(negedge clk);

        // Full write, then reads including an aliased address.
        do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1'b1, 15'd4, 32'hDEADBEEF, 0, 1'b0, hs1);
        idle(3);
        do_req(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1, 1'b0, '0, 32'h0, 0, 1'b0, hs1);
        idle(3);
        do_req(1'b0, 4'h0, 32'h20010, 32'h0, 32'hDEADBEEF, 1, 1'b0, '0, 32'h0, 0, 1'b0, hs1);
        idle(3);

        // Partial write: merge bytes 0 and 2.
        do_req(1'b1, 4'b0101, 32'h10, 32'h11223344, 32'hDE22BE44, 2, 1'b1, 15'd4, 32'hDE22BE44, 1, 1'b0, hs1);
        idle(4);
        do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDE22BE44, 1, 1'b0, '0, 32'h0, 0, 1'b0, hs1);
        idle(3);

        // Zero-strobe write: no RAM access, immediate response.
        do_req(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'hDE22BE44, 0, 1'b0, '0, 32'h0, 0, 1'b0, hs1);
        idle(3);
        check("zero_strobe_ram_word", mem[4], 32'hDE22BE44);

        // req held across two reads: second handshake three edges after the first.
        do_req(1'b0, 4'h0, 32'h0, 32'h0, 32'hA5A5_0001, 1, 1'b0, '0, 32'h0, 0, 1'b1, hs1);
        check("first_ram_a", {17'b0, ram_a}, 32'd0);
        do_req(1'b0, 4'h0, 32'h1FFFC, 32'h0, 32'h7FFF_C0DE, 1, 1'b0, '0, 32'h0, 0, 1'b0, hs2);
        check("second_ram_a", {17'b0, ram_a}, 32'h7FFF);
        check("back_to_back_spacing", hs2 - hs1, 3);
        idle(3);

        // Reset during the READ phase of a partial write drops the request.
        req = 1'b1; wr = 1'b1; wstrb = 4'b0011; addr = 32'h10; wdata = 32'h55667788;
        #1;
        check("abort_addr_ok", {31'b0, addr_ok}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_addr_ok_in_reset", {31'b0, addr_ok}, 32'd0);
        check("abort_ram_we", {31'b0, ram_we}, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_addr_ok_return", {31'b0, addr_ok}, 32'd1);
        idle(4);
        check("abort_ram_word", mem[4], 32'hDE22BE44);
        do_req(1'b0, 4'h0, 32'h10, 32'h0, 32'hDE22BE44, 1, 1'b0, '0, 32'h0, 0, 1'b0, hs1);
        idle(4);

        check("rsp_queue_drained", rsp_q.size(), 0);
        check("wr_queue_drained", wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
